// File: rtl/clock_ratio_meter_pkg.sv
// rtl/clock_ratio_meter_pkg.sv - shared FSM encoding, defaults and helpers for clock_ratio_meter
package clock_ratio_meter_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_MEASURE = 2'd1;
    localparam logic [1:0] ST_LOCKED  = 2'd2;
    localparam logic [1:0] ST_LOST    = 2'd3;

    // Default parameter values
    localparam int unsigned DEF_SYNC_STAGES = 2;
    localparam int unsigned DEF_TIMEOUT     = 50_000_000;
    localparam int unsigned DEF_LOCK_COUNT  = 4;
    localparam int unsigned DEF_TOLERANCE   = 1;

    // Saturation value of the interval counter
    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    // Absolute difference of two unsigned interval measurements
    function automatic logic [31:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/clock_ratio_meter_sync_edge_detect.sv
// rtl/clock_ratio_meter_sync_edge_detect.sv - slow_in synchronizer with any-edge detect
module sync_edge_detect
    import clock_ratio_meter_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clock_in,
    input  logic reset_n,
    input  logic async_in,
    output logic level_o,
    output logic edge_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   level_q;
    logic                   edge_q;

    // Shift the async input through the synchronizer; flag any change of the synchronized value
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], async_in};
            level_q <= sync_q[SYNC_STAGES-1];
            edge_q  <= sync_q[SYNC_STAGES-1] ^ level_q;
        end
    end

    assign level_o = level_q;
    assign edge_o  = edge_q;

endmodule

// File: rtl/clock_ratio_meter.sv
// rtl/clock_ratio_meter.sv - measures slow_in half period in clock_in cycles and tracks lock
module clock_ratio_meter
    import clock_ratio_meter_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int unsigned TIMEOUT     = DEF_TIMEOUT,
    parameter int unsigned LOCK_COUNT  = DEF_LOCK_COUNT,
    parameter int unsigned TOLERANCE   = DEF_TOLERANCE
) (
    input  logic        clock_in,
    input  logic        reset_n,
    input  logic        slow_in,
    output logic [31:0] half_period,
    output logic        meas_valid,
    output logic        locked,
    output logic        lost
);

    localparam logic [31:0] TIMEOUT_M1 = 32'(TIMEOUT - 1);
    localparam logic [31:0] LOCK_CNT32 = 32'(LOCK_COUNT);
    localparam logic [31:0] TOL32      = 32'(TOLERANCE);

    logic        slow_level_unused;
    logic        slow_edge;

    logic [1:0]  state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] half_q, half_d;
    logic        meas_valid_q, meas_valid_d;
    logic        locked_q, locked_d;
    logic        lost_q, lost_d;
    logic [31:0] match_cnt_q, match_cnt_d;
    logic        first_q, first_d;

    logic [31:0] meas_val;
    logic [31:0] match_inc;
    logic        is_match;
    logic        timeout_hit;

    sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clock_in (clock_in),
        .reset_n  (reset_n),
        .async_in (slow_in),
        .level_o  (slow_level_unused),
        .edge_o   (slow_edge)
    );

    // The interval just ended is cnt+1 cycles long, held at the saturation value
    assign meas_val    = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 32'd1;
    assign is_match    = !first_q && (abs_diff(meas_val, half_q) <= TOL32);
    assign match_inc   = (match_cnt_q == LOCK_CNT32) ? match_cnt_q : match_cnt_q + 32'd1;
    assign timeout_hit = (cnt_q == TIMEOUT_M1);

    // Next-state logic: interval counter, measurement capture and lock/loss FSM
    always_comb begin
        state_d      = state_q;
        half_d       = half_q;
        meas_valid_d = 1'b0;
        locked_d     = locked_q;
        lost_d       = lost_q;
        match_cnt_d  = match_cnt_q;
        first_d      = first_q;

        if (slow_edge) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 32'd1;
        end

        case (state_q)
            ST_IDLE: begin
                // First edge only opens an interval; the one before it was partial
                if (slow_edge) begin
                    state_d = ST_MEASURE;
                    first_d = 1'b1;
                end else if (timeout_hit) begin
                    state_d     = ST_LOST;
                    lost_d      = 1'b1;
                    locked_d    = 1'b0;
                    match_cnt_d = '0;
                end
            end
            ST_MEASURE, ST_LOCKED: begin
                if (slow_edge) begin
                    half_d       = meas_val;
                    meas_valid_d = 1'b1;
                    first_d      = 1'b0;
                    if (is_match) begin
                        match_cnt_d = match_inc;
                        if (match_inc >= LOCK_CNT32) begin
                            state_d  = ST_LOCKED;
                            locked_d = 1'b1;
                        end
                    end else begin
                        // A mismatch dropping out of lock still becomes the reference for the next one
                        match_cnt_d = '0;
                        locked_d    = 1'b0;
                        state_d     = ST_MEASURE;
                    end
                end else if (timeout_hit) begin
                    state_d     = ST_LOST;
                    lost_d      = 1'b1;
                    locked_d    = 1'b0;
                    match_cnt_d = '0;
                end
            end
            ST_LOST: begin
                // Recovery edge closes an interval of unknown length, so it is not reported
                if (slow_edge) begin
                    state_d     = ST_MEASURE;
                    lost_d      = 1'b0;
                    first_d     = 1'b1;
                    match_cnt_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with asynchronous clear
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            half_q       <= '0;
            meas_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            lost_q       <= 1'b0;
            match_cnt_q  <= '0;
            first_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            half_q       <= half_d;
            meas_valid_q <= meas_valid_d;
            locked_q     <= locked_d;
            lost_q       <= lost_d;
            match_cnt_q  <= match_cnt_d;
            first_q      <= first_d;
        end
    end

    assign half_period = half_q;
    assign meas_valid  = meas_valid_q;
    assign locked      = locked_q;
    assign lost        = lost_q;

endmodule

// File: tb/tb_clock_ratio_meter.sv
// tb/tb_clock_ratio_meter.sv - randomized self-checking bench for clock_ratio_meter
module tb_clock_ratio_meter;

    localparam int S   = 2;
    localparam int TO  = 100;
    localparam int LC  = 4;
    localparam int TOL = 1;

    logic        clock_in = 1'b0;
    logic        reset_n  = 1'b0;
    logic        slow_in  = 1'b0;
    logic [31:0] half_period;
    logic        meas_valid;
    logic        locked;
    logic        lost;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clock_in = ~clock_in;

    clock_ratio_meter #(
        .SYNC_STAGES (S),
        .TIMEOUT     (TO),
        .LOCK_COUNT  (LC),
        .TOLERANCE   (TOL)
    ) dut (
        .clock_in    (clock_in),
        .reset_n     (reset_n),
        .slow_in     (slow_in),
        .half_period (half_period),
        .meas_valid  (meas_valid),
        .locked      (locked),
        .lost        (lost)
    );

    // Reference model: edges are timestamps; a measurement is the gap between edge timestamps
    int          cyc = 0;
    int          sched[$];
    bit          m_prev_sample;
    bit          m_armed;
    bit          m_have_ref;
    int          m_last_e;
    int          m_matches;
    logic [31:0] m_half;
    bit          m_mv, m_locked, m_lost;
    bit          m_ev, m_match;
    int          m_d, m_diff;

    always @(posedge clock_in) begin
        cyc++;
        if (!reset_n) begin
            sched.delete();
            m_prev_sample = 1'b0;
            m_armed       = 1'b0;
            m_have_ref    = 1'b0;
            m_last_e      = cyc;
            m_matches     = 0;
            m_half        = '0;
            m_mv          = 1'b0;
            m_locked      = 1'b0;
            m_lost        = 1'b0;
        end else begin
            m_ev = (sched.size() > 0) && (sched[0] == cyc);
            if (m_ev) void'(sched.pop_front());
            if (slow_in !== m_prev_sample) begin
                sched.push_back(cyc + S + 1);
                m_prev_sample = slow_in;
            end
            m_mv = 1'b0;
            if (m_ev) begin
                if (!m_armed || m_lost) begin
                    m_armed    = 1'b1;
                    m_lost     = 1'b0;
                    m_have_ref = 1'b0;
                end else begin
                    m_d    = cyc - m_last_e;
                    m_diff = m_d - int'(m_half);
                    if (m_diff < 0) m_diff = -m_diff;
                    m_match    = m_have_ref && (m_diff <= TOL);
                    m_half     = 32'(m_d);
                    m_have_ref = 1'b1;
                    m_mv       = 1'b1;
                    if (m_match) begin
                        m_matches++;
                        if (m_matches >= LC) m_locked = 1'b1;
                    end else begin
                        m_matches = 0;
                        m_locked  = 1'b0;
                    end
                end
                m_last_e = cyc;
            end else if (!m_lost && (cyc - m_last_e == TO)) begin
                m_lost    = 1'b1;
                m_locked  = 1'b0;
                m_matches = 0;
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge
    logic [31:0] e_half;
    logic        e_mv, e_locked, e_lost;

    always @(negedge clock_in) begin
        if (!reset_n) begin
            e_half = '0; e_mv = 1'b0; e_locked = 1'b0; e_lost = 1'b0;
        end else begin
            e_half = m_half; e_mv = m_mv; e_locked = m_locked; e_lost = m_lost;
        end
        vectors++;
        if (half_period !== e_half || meas_valid !== e_mv || locked !== e_locked || lost !== e_lost) begin
            miscompares++;
            $display("FAIL cycle_compare cyc=%0d half_period got %0d exp %0d, meas_valid got %0b exp %0b, locked got %0b exp %0b, lost got %0b exp %0b",
                     cyc, half_period, e_half, meas_valid, e_mv, locked, e_locked, lost, e_lost);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    int lat;
    bit lost_seen;

    // Toggle slow_in now, then hold it for d cycles; record when meas_valid first shows
    task automatic step(input int d);
        lat     = -1;
        slow_in = ~slow_in;
        for (int n = 1; n <= d; n++) begin
            @(posedge clock_in);
            #1;
            if (meas_valid && lat < 0) lat = n;
            if (lost) lost_seen = 1'b1;
        end
    endtask

    initial begin
        int base;
        int d;
        int lat_lock;
        int steps_a[8];
        int steps_b[10];

        steps_a = '{5, 5, 5, 5, 5, 5, 5, 5};
        steps_b = '{12, 5, 6, 5, 6, 5, 6, 5, 8, 5};

        // Reset state
        repeat (3) @(posedge clock_in);
        #1;
        check("reset_half_period", half_period, 32'd0);
        check("reset_meas_valid", 32'(meas_valid), 32'd0);
        check("reset_locked", 32'(locked), 32'd0);
        check("reset_lost", 32'(lost), 32'd0);
        #3 reset_n = 1'b1;
        @(posedge clock_in);
        #1;

        // Divide-by-5: lock on the sixth edge, not before
        lat_lock = -1;
        for (int i = 0; i < 8; i++) begin
            step(steps_a[i]);
            if (i == 4) check("div5_not_locked_after_5th_edge", 32'(locked), 32'd0);
            if (i == 5) begin
                lat_lock = lat;
                check("div5_locked_after_6th_edge", 32'(locked), 32'd1);
            end
        end
        check("div5_half_period", half_period, 32'd5);
        check("meas_latency", 32'(lat_lock), 32'(S + 2));

        // Alternating 5/6 locks within tolerance; a jump to 8 drops lock
        for (int i = 0; i < 10; i++) begin
            step(steps_b[i]);
            if (i == 7) check("alt56_locked", 32'(locked), 32'd1);
        end
        check("jump8_unlocked", 32'(locked), 32'd0);
        check("jump8_half_period", half_period, 32'd8);

        // Randomized intervals, occasionally straddling the timeout
        base = 5;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 5) == 0) base = $urandom_range(1, 12);
            if ($urandom_range(0, 9) == 0) d = $urandom_range(97, 103);
            else d = base + $urandom_range(0, 1);
            step(d);
        end

        // Relock, then starve slow_in until lost
        repeat (7) step(5);
        check("relock_before_timeout", 32'(locked), 32'd1);
        repeat (120) @(posedge clock_in);
        #1;
        check("timeout_lost", 32'(lost), 32'd1);
        check("timeout_unlocked", 32'(locked), 32'd0);
        check("timeout_half_holds", half_period, 32'd5);
        step(6);
        check("lost_exit_no_meas", 32'(lat), 32'hFFFF_FFFF);
        check("lost_cleared", 32'(lost), 32'd0);

        // Interval of exactly TIMEOUT: the edge wins
        lost_seen = 1'b0;
        step(TO);
        step(5);
        check("edge_at_timeout_no_lost", 32'(lost_seen), 32'd0);
        check("edge_at_timeout_half", half_period, 32'(TO));

        // Reset while locked, mid-interval
        repeat (7) step(5);
        check("locked_before_reset", 32'(locked), 32'd1);
        repeat (2) @(posedge clock_in);
        #3 reset_n = 1'b0;
        #1;
        check("midreset_half_period", half_period, 32'd0);
        check("midreset_locked", 32'(locked), 32'd0);
        check("midreset_meas_valid", 32'(meas_valid), 32'd0);
        check("midreset_lost", 32'(lost), 32'd0);
        slow_in = 1'b0;
        repeat (3) @(posedge clock_in);
        #4 reset_n = 1'b1;
        @(posedge clock_in);
        #1;
        step(8);
        check("post_reset_first_edge_no_meas", 32'(lat), 32'hFFFF_FFFF);
        step(8);
        check("post_reset_meas_latency", 32'(lat), 32'(S + 2));
        check("post_reset_half_period", half_period, 32'd8);

        repeat (5) @(posedge clock_in);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
